lockstep_mode_ctrl: RTL and testbench
=====================================

// Module: lockstep_mode_ctrl
// PURPOSE
//  Sequences the dual-hart CPU cluster between independent mode and DMR lockstep mode.
//  Halts both harts through debug requests and waits for each hart's sync acknowledgement.
//  Flips the lockstep select that drives the safety multiplexer, then compares hart 0 and
//  hart 1 data-bus requests every cycle while in lockstep.
//  Sits beside the safe-wrapper CSR block; its sync inputs are that block's per-hart sync
//  strobes.
// PARAMETERS
//  AW       32    data-bus address width
//  DW       32    data-bus write-data width
//  TIMEOUT  1024  max cycles in WAIT_SYNC before a timeout fault; 0 = no timeout
// PORTS
//  clk_i            in   1     clock
//  rst_i            in   1     synchronous reset, active-high
//  switch_req_i     in   1     1-cycle pulse: request mode change
//  switch_target_i  in   1     target sampled with switch_req_i: 1 = lockstep, 0 = independent
//  sync_i           in   2     per-hart sync strobe (bit h = hart h reached its sync point)
//  clear_fault_i    in   1     pulse: leave FAULT
//  cmp_req_i        in   2     data-bus req of hart 1/0
//  cmp_we_i         in   2     data-bus we of hart 1/0
//  cmp_addr_i       in   2*AW  {hart1 addr, hart0 addr}
//  cmp_wdata_i      in   2*DW  {hart1 wdata, hart0 wdata}
//  debug_req_o      out  2     per-hart halt request to the cores
//  lockstep_o       out  1     1 = safety multiplexer in lockstep configuration
//  busy_o           out  1     1 while state is WAIT_SYNC or RESUME
//  mismatch_o       out  1     1-cycle pulse on a compare mismatch
//  fault_o          out  1     1 while state is FAULT
//  fault_cause_o    out  2     01 = mismatch, 10 = sync timeout; valid while fault_o = 1
//  state_o          out  3     INDEP=0 WAIT_SYNC=1 RESUME=2 LOCKSTEP=3 FAULT=4
// BEHAVIOUR
//  Reset
//   - state = INDEP; all outputs 0.
//   - Sync flags, target register and timeout counter are cleared.
//   - Reset asserted in any state returns to INDEP on the next edge.
//  INDEP
//   - lockstep_o = 0.
//   - switch_req_i with target = 1: latch target, go to WAIT_SYNC.
//   - switch_req_i with target = 0: ignored.
//  LOCKSTEP
//   - lockstep_o = 1.
//   - switch_req_i with target = 0: latch target, go to WAIT_SYNC.
//   - switch_req_i with target = 1: ignored.
//  WAIT_SYNC
//   - debug_req_o[h] = ~flag[h]. flag[h] is set by sync_i[h] and is sticky.
//   - Both strobes in the same cycle set both flags.
//   - Both flags set: go to RESUME on the next edge, with debug_req_o = 0 in RESUME.
//   - Timeout counter increments each cycle in this state.
//   - Counter == TIMEOUT-1 with flags incomplete (TIMEOUT > 0): go to FAULT, cause = 10.
//   - lockstep_o holds its pre-switch value.
//  RESUME
//   - Lasts exactly 1 cycle; clears flags and counter.
//   - Next state is LOCKSTEP if target = 1, else INDEP.
//   - lockstep_o takes the target value in the cycle after RESUME.
//  Compare (LOCKSTEP only)
//   - Combinational check each cycle. Mismatch if any of:
//     - cmp_req_i[0] != cmp_req_i[1];
//     - both req and we differ;
//     - both req and addr differs;
//     - both req and we = 1 and wdata differs.
//   - On mismatch: mismatch_o = 1 for the next cycle, state goes to FAULT, cause = 01.
//   - Compare outside LOCKSTEP is disabled.
//  FAULT
//   - debug_req_o = 11 (both harts held halted).
//   - lockstep_o = 0, fault_o = 1.
//   - clear_fault_i: go to INDEP next cycle; cause and outputs cleared.
//  Ignored inputs and collisions
//   - switch_req_i is ignored in WAIT_SYNC, RESUME and FAULT.
//   - sync_i is ignored outside WAIT_SYNC.
//   - clear_fault_i is ignored outside FAULT.
//   - Mismatch and switch_req_i in the same cycle: mismatch wins, the switch is dropped.
//  Widths and outputs
//   - Timeout counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.
//   - All outputs are registered except busy_o and fault_o, which decode the state register.
// TESTING
//  1. Reset, pulse switch_req_i (target = 1); sync_i = 01 at cycle 3, then 10 at cycle 6
//     -> debug_req_o 11 -> 10 -> 00; RESUME one cycle; lockstep_o = 1 and state = 3 after.
//  2. In LOCKSTEP, both harts req = 1, we = 1, addr 0x100, wdata 0xA5 vs 0xA4
//     -> mismatch_o pulse, fault_cause_o = 01, debug_req_o = 11, lockstep_o = 0.
//  3. TIMEOUT = 8, enter WAIT_SYNC with only sync_i[0] pulsed
//     -> FAULT after 8 cycles, fault_cause_o = 10; clear_fault_i -> state 0, all outputs 0.
//  4. In LOCKSTEP, identical reads with wdata differing (we = 0) -> no mismatch.
//     Then switch_req_i (target = 0) plus both syncs -> lockstep_o = 0, state 0.
//  5. switch_req_i during WAIT_SYNC, and mismatch plus switch_req_i in the same cycle
//     -> first ignored; second goes to FAULT with cause 01.
//  6. Assert rst_i mid-WAIT_SYNC with flag[0] set -> next cycle state 0, outputs 0.
//     A new request must see both syncs again.

Source files
------------

// File: rtl/lockstep_mode_ctrl.sv
// lockstep_mode_ctrl: moves the dual-hart cluster between independent and DMR
// lockstep mode. Both harts are halted via debug requests until each reports
// its sync point, then the lockstep select flips. While in lockstep the two
// harts' data-bus requests are compared every cycle; divergence or a sync
// timeout parks the cluster in FAULT with both harts held halted.
module lockstep_mode_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            switch_req_i,
  input  logic            switch_target_i,
  input  logic [1:0]      sync_i,
  input  logic            clear_fault_i,
  input  logic [1:0]      cmp_req_i,
  input  logic [1:0]      cmp_we_i,
  input  logic [2*AW-1:0] cmp_addr_i,
  input  logic [2*DW-1:0] cmp_wdata_i,
  output logic [1:0]      debug_req_o,
  output logic            lockstep_o,
  output logic            busy_o,
  output logic            mismatch_o,
  output logic            fault_o,
  output logic [1:0]      fault_cause_o,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    S_INDEP  = 3'd0,
    S_WAIT   = 3'd1,
    S_RESUME = 3'd2,
    S_LOCK   = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  // Counter is wide enough to hold TIMEOUT; kept at 1 bit when timeout is off.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] CAUSE_MISMATCH = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  state_e        state_q;
  logic [1:0]    flags_q, flags_d;
  logic          target_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    debug_req_q;
  logic          lockstep_q;
  logic          mismatch_q;
  logic [1:0]    cause_q;

  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata;
  logic               diverge;
  logic               cmp_mis;

  assign addr  = cmp_addr_i;
  assign wdata = cmp_wdata_i;

  // Sync strobes accumulate into sticky per-hart flags.
  assign flags_d = flags_q | sync_i;

  // Bus divergence check; wdata only matters for writes.
  always_comb begin
    diverge = 1'b0;
    if (cmp_req_i[0] != cmp_req_i[1])      diverge = 1'b1;
    else if (cmp_req_i[0]) begin
      if (cmp_we_i[0] != cmp_we_i[1])      diverge = 1'b1;
      else if (addr[0] != addr[1])         diverge = 1'b1;
      else if (cmp_we_i[0] && (wdata[0] != wdata[1])) diverge = 1'b1;
    end
  end

  assign cmp_mis = (state_q == S_LOCK) && diverge;

  // Mode sequencer; every output is computed alongside the state it belongs to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_INDEP;
      flags_q     <= '0;
      target_q    <= 1'b0;
      cnt_q       <= '0;
      debug_req_q <= '0;
      lockstep_q  <= 1'b0;
      mismatch_q  <= 1'b0;
      cause_q     <= '0;
    end else begin
      mismatch_q <= 1'b0;
      case (state_q)
        S_INDEP: begin
          flags_q <= '0;
          cnt_q   <= '0;
          if (switch_req_i && switch_target_i) begin
            target_q    <= 1'b1;
            state_q     <= S_WAIT;
            debug_req_q <= 2'b11;
          end
        end
        S_LOCK: begin
          flags_q <= '0;
          cnt_q   <= '0;
          // Mismatch takes priority over a concurrent switch request.
          if (cmp_mis) begin
            state_q     <= S_FAULT;
            mismatch_q  <= 1'b1;
            cause_q     <= CAUSE_MISMATCH;
            debug_req_q <= 2'b11;
            lockstep_q  <= 1'b0;
          end else if (switch_req_i && !switch_target_i) begin
            target_q    <= 1'b0;
            state_q     <= S_WAIT;
            debug_req_q <= 2'b11;
          end
        end
        S_WAIT: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          flags_q <= flags_d;
          if (&flags_d) begin
            state_q     <= S_RESUME;
            debug_req_q <= 2'b00;
          end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
            state_q     <= S_FAULT;
            cause_q     <= CAUSE_TIMEOUT;
            debug_req_q <= 2'b11;
            lockstep_q  <= 1'b0;
          end else begin
            debug_req_q <= ~flags_d;
          end
        end
        S_RESUME: begin
          flags_q    <= '0;
          cnt_q      <= '0;
          lockstep_q <= target_q;
          state_q    <= target_q ? S_LOCK : S_INDEP;
        end
        S_FAULT: begin
          flags_q <= '0;
          cnt_q   <= '0;
          if (clear_fault_i) begin
            state_q     <= S_INDEP;
            cause_q     <= '0;
            debug_req_q <= '0;
          end
        end
        default: begin
          state_q     <= S_INDEP;
          debug_req_q <= '0;
          lockstep_q  <= 1'b0;
          cause_q     <= '0;
        end
      endcase
    end
  end

  assign state_o       = state_q;
  assign debug_req_o   = debug_req_q;
  assign lockstep_o    = lockstep_q;
  assign mismatch_o    = mismatch_q;
  assign fault_cause_o = cause_q;
  assign busy_o        = (state_q == S_WAIT) || (state_q == S_RESUME);
  assign fault_o       = (state_q == S_FAULT);

endmodule

// File: tb/tb_lockstep_mode_ctrl.sv
// Directed bench for lockstep_mode_ctrl; outputs are sampled 1 time unit after
// each rising edge and compared as one packed vector
// {state, debug_req, lockstep, busy, mismatch, fault, cause}.
module tb_lockstep_mode_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i, switch_req_i, switch_target_i, clear_fault_i;
  logic [1:0]    sync_i, cmp_req_i, cmp_we_i;
  logic [2*AW-1:0] cmp_addr_i;
  logic [2*DW-1:0] cmp_wdata_i;
  logic [1:0]    debug_req_o, fault_cause_o;
  logic          lockstep_o, busy_o, mismatch_o, fault_o;
  logic [2:0]    state_o;

  int checks = 0;
  int errs   = 0;

  lockstep_mode_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .switch_req_i(switch_req_i),
    .switch_target_i(switch_target_i), .sync_i(sync_i),
    .clear_fault_i(clear_fault_i), .cmp_req_i(cmp_req_i), .cmp_we_i(cmp_we_i),
    .cmp_addr_i(cmp_addr_i), .cmp_wdata_i(cmp_wdata_i),
    .debug_req_o(debug_req_o), .lockstep_o(lockstep_o), .busy_o(busy_o),
    .mismatch_o(mismatch_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {state_o, debug_req_o, lockstep_o, busy_o, mismatch_o, fault_o, fault_cause_o};
  endfunction

  function automatic logic [10:0] E(input logic [2:0] st, input logic [1:0] dbg,
                                    input logic ls, input logic bz, input logic mis,
                                    input logic ft, input logic [1:0] cs);
    return {st, dbg, ls, bz, mis, ft, cs};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    switch_req_i = 0; switch_target_i = 0; sync_i = 0; clear_fault_i = 0;
    cmp_req_i = 0; cmp_we_i = 0; cmp_addr_i = '0; cmp_wdata_i = '0;
  endtask

  // Brings the DUT from INDEP to LOCKSTEP with both syncs in one cycle.
  task automatic go_lockstep();
    switch_req_i = 1; switch_target_i = 1; tick(); switch_req_i = 0;
    sync_i = 2'b11; tick(); sync_i = 0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs(); rst_i = 1; tick(); tick(); rst_i = 0;
    checks++; if (outs() !== E(0,2'b00,0,0,0,0,2'b00)) begin errs++;
      $display("FAIL reset got=%b exp=%b", outs(), E(0,2'b00,0,0,0,0,2'b00)); end
  endtask

  task automatic test_enter_lockstep();
    switch_req_i = 1; switch_target_i = 1; tick(); switch_req_i = 0;
    checks++; if (outs() !== E(1,2'b11,0,1,0,0,2'b00)) begin errs++;
      $display("FAIL t1_wait_enter got=%b exp=%b", outs(), E(1,2'b11,0,1,0,0,2'b00)); end
    tick();
    sync_i = 2'b01; tick(); sync_i = 0;
    checks++; if (outs() !== E(1,2'b10,0,1,0,0,2'b00)) begin errs++;
      $display("FAIL t1_hart0_sync got=%b exp=%b", outs(), E(1,2'b10,0,1,0,0,2'b00)); end
    tick(); tick();
    sync_i = 2'b10; tick(); sync_i = 0;
    checks++; if (outs() !== E(2,2'b00,0,1,0,0,2'b00)) begin errs++;
      $display("FAIL t1_resume got=%b exp=%b", outs(), E(2,2'b00,0,1,0,0,2'b00)); end
    tick();
    checks++; if (outs() !== E(3,2'b00,1,0,0,0,2'b00)) begin errs++;
      $display("FAIL t1_lockstep got=%b exp=%b", outs(), E(3,2'b00,1,0,0,0,2'b00)); end
  endtask

  task automatic test_mismatch();
    cmp_req_i = 2'b11; cmp_we_i = 2'b11;
    cmp_addr_i = {32'h100, 32'h100}; cmp_wdata_i = {32'hA4, 32'hA5};
    tick(); cmp_req_i = 0; cmp_we_i = 0;
    checks++; if (outs() !== E(4,2'b11,0,0,1,1,2'b01)) begin errs++;
      $display("FAIL t2_mismatch got=%b exp=%b", outs(), E(4,2'b11,0,0,1,1,2'b01)); end
    tick();
    checks++; if (outs() !== E(4,2'b11,0,0,0,1,2'b01)) begin errs++;
      $display("FAIL t2_pulse_end got=%b exp=%b", outs(), E(4,2'b11,0,0,0,1,2'b01)); end
    clear_fault_i = 1; tick(); clear_fault_i = 0;
    checks++; if (outs() !== E(0,2'b00,0,0,0,0,2'b00)) begin errs++;
      $display("FAIL t2_clear got=%b exp=%b", outs(), E(0,2'b00,0,0,0,0,2'b00)); end
  endtask

  task automatic test_timeout();
    clear_fault_i = 1; tick(); clear_fault_i = 0;  // ignored outside FAULT
    switch_req_i = 1; switch_target_i = 1; tick(); switch_req_i = 0;
    sync_i = 2'b01; tick(); sync_i = 0;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (outs() !== E(1,2'b10,0,1,0,0,2'b00)) begin errs++;
      $display("FAIL t3_before_timeout got=%b exp=%b", outs(), E(1,2'b10,0,1,0,0,2'b00)); end
    tick();
    checks++; if (outs() !== E(4,2'b11,0,0,0,1,2'b10)) begin errs++;
      $display("FAIL t3_timeout got=%b exp=%b", outs(), E(4,2'b11,0,0,0,1,2'b10)); end
    switch_req_i = 1; switch_target_i = 1; tick(); switch_req_i = 0;
    checks++; if (outs() !== E(4,2'b11,0,0,0,1,2'b10)) begin errs++;
      $display("FAIL t3_switch_in_fault got=%b exp=%b", outs(), E(4,2'b11,0,0,0,1,2'b10)); end
    clear_fault_i = 1; tick(); clear_fault_i = 0;
    checks++; if (outs() !== E(0,2'b00,0,0,0,0,2'b00)) begin errs++;
      $display("FAIL t3_clear got=%b exp=%b", outs(), E(0,2'b00,0,0,0,0,2'b00)); end
  endtask

  task automatic test_read_and_exit();
    // Diverging bus and a return-to-independent request are both ignored in INDEP.
    cmp_req_i = 2'b01; switch_req_i = 1; switch_target_i = 0; tick();
    cmp_req_i = 0; switch_req_i = 0;
    checks++; if (outs() !== E(0,2'b00,0,0,0,0,2'b00)) begin errs++;
      $display("FAIL t4_indep_ignore got=%b exp=%b", outs(), E(0,2'b00,0,0,0,0,2'b00)); end
    go_lockstep();
    cmp_req_i = 2'b11; cmp_we_i = 2'b00;
    cmp_addr_i = {32'h200, 32'h200}; cmp_wdata_i = {32'h1234, 32'h5678};
    tick(); cmp_req_i = 0;
    checks++; if (outs() !== E(3,2'b00,1,0,0,0,2'b00)) begin errs++;
      $display("FAIL t4_read_match got=%b exp=%b", outs(), E(3,2'b00,1,0,0,0,2'b00)); end
    switch_req_i = 1; switch_target_i = 0; tick(); switch_req_i = 0;
    checks++; if (outs() !== E(1,2'b11,1,1,0,0,2'b00)) begin errs++;
      $display("FAIL t4_exit_wait got=%b exp=%b", outs(), E(1,2'b11,1,1,0,0,2'b00)); end
    sync_i = 2'b11; tick(); sync_i = 0;
    checks++; if (outs() !== E(2,2'b00,1,1,0,0,2'b00)) begin errs++;
      $display("FAIL t4_exit_resume got=%b exp=%b", outs(), E(2,2'b00,1,1,0,0,2'b00)); end
    tick();
    checks++; if (outs() !== E(0,2'b00,0,0,0,0,2'b00)) begin errs++;
      $display("FAIL t4_indep got=%b exp=%b", outs(), E(0,2'b00,0,0,0,0,2'b00)); end
  endtask

  task automatic test_collisions();
    switch_req_i = 1; switch_target_i = 1; tick();
    switch_target_i = 0; tick(); switch_req_i = 0;  // dropped in WAIT_SYNC
    sync_i = 2'b11; tick(); sync_i = 0; tick();
    checks++; if (outs() !== E(3,2'b00,1,0,0,0,2'b00)) begin errs++;
      $display("FAIL t5_switch_in_wait got=%b exp=%b", outs(), E(3,2'b00,1,0,0,0,2'b00)); end
    cmp_req_i = 2'b01; switch_req_i = 1; switch_target_i = 0; tick();
    cmp_req_i = 0; switch_req_i = 0;
    checks++; if (outs() !== E(4,2'b11,0,0,1,1,2'b01)) begin errs++;
      $display("FAIL t5_mismatch_wins got=%b exp=%b", outs(), E(4,2'b11,0,0,1,1,2'b01)); end
    clear_fault_i = 1; tick(); clear_fault_i = 0;
  endtask

  task automatic test_reset_mid_wait();
    sync_i = 2'b11; tick(); sync_i = 0;  // ignored outside WAIT_SYNC
    switch_req_i = 1; switch_target_i = 1; tick(); switch_req_i = 0;
    checks++; if (outs() !== E(1,2'b11,0,1,0,0,2'b00)) begin errs++;
      $display("FAIL t6_stale_sync got=%b exp=%b", outs(), E(1,2'b11,0,1,0,0,2'b00)); end
    sync_i = 2'b01; tick(); sync_i = 0;
    rst_i = 1; tick(); rst_i = 0;
    checks++; if (outs() !== E(0,2'b00,0,0,0,0,2'b00)) begin errs++;
      $display("FAIL t6_reset got=%b exp=%b", outs(), E(0,2'b00,0,0,0,0,2'b00)); end
    switch_req_i = 1; switch_target_i = 1; tick(); switch_req_i = 0;
    sync_i = 2'b10; tick(); sync_i = 0;
    checks++; if (outs() !== E(1,2'b01,0,1,0,0,2'b00)) begin errs++;
      $display("FAIL t6_flag_cleared got=%b exp=%b", outs(), E(1,2'b01,0,1,0,0,2'b00)); end
    sync_i = 2'b01; tick(); sync_i = 0; tick();
    checks++; if (outs() !== E(3,2'b00,1,0,0,0,2'b00)) begin errs++;
      $display("FAIL t6_relock got=%b exp=%b", outs(), E(3,2'b00,1,0,0,0,2'b00)); end
  endtask

  initial begin
    rst_i = 1; idle_inputs();
    test_reset();
    test_enter_lockstep();
    test_mismatch();
    test_timeout();
    test_read_and_exit();
    test_collisions();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
